crossbar_seq: RTL
=================

CROSSBAR_SEQ -- requirements
Module: crossbar_seq

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 4, meaning cycles each SET/RESET programming pulse is held (legal 1..255).
REQ-002 SHALL have parameter FORM_CYC, default 16, meaning cycles the whole-array form pulse is held (legal 1..255).
REQ-003 SHALL have parameter SETTLE_CYC, default 1, meaning wait cycles between read drive and result capture (legal 1..255).
REQ-004 SHALL have port clk, input, 1, meaning single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port cmd_valid, input, 1, meaning command request.
REQ-007 SHALL have port cmd_ready, output, 1, meaning command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_op, input, 2, meaning 00 FORM, 01 WRITE row, 10 MAC, 11 READ row.
REQ-009 SHALL have port cmd_row, input, 3, meaning target row for WRITE/READ.
REQ-010 SHALL have port cmd_data, input, 8, meaning WRITE row bits, or MAC wordline input vector.
REQ-011 SHALL have port rsp_valid, output, 1, meaning result available.
REQ-012 SHALL have port rsp_ready, input, 1, meaning result consumed when high with rsp_valid.
REQ-013 SHALL have port rsp_data, output, 8, meaning captured crossbar out vector.
REQ-014 SHALL have ports bitline, wordline, selectline, outputs, 8 each, meaning crossbar array drive.
REQ-015 SHALL have ports wenable, form, mac, outputs, 1 each, meaning crossbar mode strobes.
REQ-016 SHALL have port xbar_out, input, 8, meaning crossbar out bus.
REQ-017 SHALL have port busy, output, 1, meaning state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, FORM, SET, RST, GAP, RD_DRV, RD_WAIT, RSP; all array outputs registered.
REQ-019 SHALL assert cmd_ready only in IDLE; commands offered in any other state are not accepted and have no effect.
REQ-020 SHALL, on accepting FORM, enter FORM and drive wordline=FF, bitline=FF, selectline=00, wenable=1, form=1 for exactly FORM_CYC cycles, then GAP.
REQ-021 SHALL, on accepting WRITE, latch cmd_row/cmd_data, enter SET and drive wordline=onehot(row), bitline=data, selectline=00, wenable=1 for PULSE_CYC cycles.
REQ-022 SHALL then enter RST and drive wordline=onehot(row), bitline=00, selectline=~data, wenable=1 for PULSE_CYC cycles, then GAP.
REQ-023 SHALL skip SET when data=00 and skip RST when data=FF (SET/RST phase goes directly to next phase).
REQ-024 SHALL hold GAP exactly 1 cycle with all array outputs 0, then return to IDLE without a response.
REQ-025 SHALL, on accepting MAC, enter RD_DRV and drive wordline=cmd_data, bitline=00, selectline=00, mac=1, wenable=0 for 1 cycle.
REQ-026 SHALL, on accepting READ, behave as MAC with wordline=onehot(cmd_row) and mac=0.
REQ-027 SHALL hold the read drive through RD_WAIT for SETTLE_CYC cycles, capture xbar_out into rsp_data on the last RD_WAIT cycle, then enter RSP.
REQ-028 SHALL in RSP assert rsp_valid, hold rsp_data stable, and drive all array outputs 0 until rsp_valid&&rsp_ready, then return to IDLE next cycle.
REQ-029 SHALL use one 8-bit down-counter loaded with (N-1) on phase entry; phase exits when counter is 0 (N=1 gives a single-cycle phase).
REQ-030 SHALL never drive bitline[j]=1 and selectline[j]=1 simultaneously in any state.
REQ-031 SHALL accept a command presented in IDLE on the same edge it is seen; back-to-back WRITEs are separated by at least the GAP cycle plus one IDLE cycle.

Reset
REQ-032 SHALL on rst asynchronously force IDLE, counter 0, rsp_valid=0, rsp_data=00, all array outputs and strobes 0, busy=0, and cmd_ready=1 once rst deasserts.
REQ-033 SHALL abort any in-progress pulse or pending response on rst with no partial-phase completion after release.

Verification
REQ-034 WRITE row 3 data A5, defaults -> 4 cycles wordline=08/bitline=A5/sel=00, then 4 cycles bitline=00/sel=5A, 1 GAP cycle, busy low after cycle 10.
REQ-035 MAC cmd_data=0F with model crossbar returning 3C -> mac=1 and wordline=0F for 2 cycles, rsp_valid with rsp_data=3C; held 5 cycles with rsp_ready=0, released on rsp_ready=1.
REQ-036 WRITE data FF then data 00 -> first has SET only (no selectline activity), second has RST only with selectline=FF.
REQ-037 FORM -> form=1, wenable=1, wordline=FF, bitline=FF for exactly 16 cycles; cmd_valid held high meanwhile is not accepted until IDLE.
REQ-038 rst asserted mid-SET cycle 2 -> all outputs 0 immediately (before next clk edge); after release cmd_ready=1 and no RST phase occurs.
REQ-039 Every cycle of every test -> assert no column with bitline=1 and selectline=1, and cmd_ready==(state==IDLE).

Source files
------------

// File: rtl/crossbar_seq_if.sv
// crossbar_seq_if: command/response handshake bundle for the crossbar sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_row/cmd_data : command channel (master -> slave)
//   rsp_valid/rsp_ready/rsp_data                : response channel (slave -> master)
// The master modport is the command issuer; the slave modport is the sequencer.
interface crossbar_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_row;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/crossbar_seq.sv
// crossbar_seq: sequences FORM / WRITE / MAC / READ operations onto an 8x8
// resistive crossbar array.
//   clk, rst          : system clock, asynchronous active-high reset
//   bus (slave)       : command/response handshake (see crossbar_seq_if)
//   wordline, bitline, selectline : registered array drive
//   wenable, form, mac            : registered array mode strobes
//   xbar_out          : array output bus, captured at the end of a read
//   busy              : high whenever the sequencer is not idle
module crossbar_seq #(
  parameter int unsigned PULSE_CYC  = 4,
  parameter int unsigned FORM_CYC   = 16,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  crossbar_seq_if.slave bus,
  output logic [7:0]    bitline,
  output logic [7:0]    wordline,
  output logic [7:0]    selectline,
  output logic          wenable,
  output logic          form,
  output logic          mac,
  input  logic [7:0]    xbar_out,
  output logic          busy
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;

  localparam logic [1:0] OP_FORM  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_MAC   = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FORM, S_SET, S_RST, S_GAP, S_RD_DRV, S_RD_WAIT, S_RSP
  } state_e;

  typedef struct packed {
    logic [W-1:0] wl;
    logic [W-1:0] bl;
    logic [W-1:0] sl;
    logic         we;
    logic         fm;
    logic         mc;
  } drive_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  wl_q, wl_d;
  logic [W-1:0]  data_q, data_d;
  logic          is_mac_q, is_mac_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic          cmd_ready_q;
  logic          busy_q;
  drive_t        drv_q;

  // Counter preload for a phase: N-1 so that N=1 yields a one-cycle phase.
  function automatic logic [CW-1:0] load_f(input state_e st);
    case (st)
      S_FORM:       load_f = CW'(FORM_CYC - 1);
      S_SET, S_RST: load_f = CW'(PULSE_CYC - 1);
      S_RD_WAIT:    load_f = CW'(SETTLE_CYC - 1);
      default:      load_f = '0;
    endcase
  endfunction

  // Array drive pattern for a state. SET only drives bitline and RST only
  // drives selectline, so the two are never high on the same column.
  function automatic drive_t drive_f(input state_e st, input logic [W-1:0] wl,
                                     input logic [W-1:0] d, input logic m);
    drive_t r;
    r = '0;
    case (st)
      S_FORM: begin
        r.wl = '1;
        r.bl = '1;
        r.we = 1'b1;
        r.fm = 1'b1;
      end
      S_SET: begin
        r.wl = wl;
        r.bl = d;
        r.we = 1'b1;
      end
      S_RST: begin
        r.wl = wl;
        r.sl = ~d;
        r.we = 1'b1;
      end
      S_RD_DRV, S_RD_WAIT: begin
        r.wl = wl;
        r.mc = m;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Next-state, operand latch and response capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wl_d        = wl_q;
    data_d      = data_q;
    is_mac_d    = is_mac_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_FORM: state_d = S_FORM;
            OP_WRITE: begin
              wl_d    = W'(1) << bus.cmd_row;
              data_d  = bus.cmd_data;
              // All-zero data has nothing to SET.
              state_d = (bus.cmd_data == '0) ? S_RST : S_SET;
            end
            OP_MAC: begin
              wl_d     = bus.cmd_data;
              is_mac_d = 1'b1;
              state_d  = S_RD_DRV;
            end
            default: begin
              wl_d     = W'(1) << bus.cmd_row;
              is_mac_d = 1'b0;
              state_d  = S_RD_DRV;
            end
          endcase
        end
      end
      S_FORM:   if (cnt_q == '0) state_d = S_GAP;
      // All-ones data has nothing to RESET.
      S_SET:    if (cnt_q == '0) state_d = (data_q == '1) ? S_GAP : S_RST;
      S_RST:    if (cnt_q == '0) state_d = S_GAP;
      S_GAP:    state_d = S_IDLE;
      S_RD_DRV: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = xbar_out;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = load_f(state_d);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // State, counter and registered outputs; outputs follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wl_q        <= '0;
      data_q      <= '0;
      is_mac_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      drv_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wl_q        <= wl_d;
      data_q      <= data_d;
      is_mac_q    <= is_mac_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      drv_q       <= drive_f(state_d, wl_d, data_d, is_mac_d);
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign wordline      = drv_q.wl;
  assign bitline       = drv_q.bl;
  assign selectline    = drv_q.sl;
  assign wenable       = drv_q.we;
  assign form          = drv_q.fm;
  assign mac           = drv_q.mc;
  assign busy          = busy_q;

endmodule
